cpu_bus_arbiter: RTL



---
 rtl/cpu_bus_pkg.sv | 31 +++
 rtl/cpu_bus_arbiter_if.sv | 45 ++++
 rtl/cpu_bus_watchdog.sv | 40 ++++
 rtl/cpu_bus_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared state, owner and sizing definitions for CPU bus arbiters
package cpu_bus_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MEM   = 2'd2
    } bus_state_e;

    // Owner codes are port-generic so an I-cache/D-cache arbiter can share them.
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_PORT0 = 2'd1,
        OWNER_PORT1 = 2'd2
    } grant_owner_e;

    function automatic grant_owner_e state_owner(input bus_state_e state);
        case (state)
            FETCH:   return OWNER_PORT0;
            MEM:     return OWNER_PORT1;
            default: return OWNER_NONE;
        endcase
    endfunction

    function automatic int counter_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// rtl/cpu_bus_arbiter_if.sv - fetch, memory-stage and bus signals around the arbiter
interface cpu_bus_arbiter_if;
    import cpu_bus_pkg::*;

    logic                 i_fetch_request;
    logic [BUS_WIDTH-1:0] i_fetch_address;
    logic                 o_fetch_ready;
    logic [BUS_WIDTH-1:0] o_fetch_rdata;

    logic                 i_mem_request;
    logic                 i_mem_rw;
    logic [BUS_WIDTH-1:0] i_mem_address;
    logic [BUS_WIDTH-1:0] i_mem_wdata;
    logic                 o_mem_ready;
    logic [BUS_WIDTH-1:0] o_mem_rdata;

    logic                 o_bus_request;
    logic                 o_bus_rw;
    logic [BUS_WIDTH-1:0] o_bus_address;
    logic [BUS_WIDTH-1:0] o_bus_wdata;
    logic                 i_bus_ready;
    logic [BUS_WIDTH-1:0] i_bus_rdata;

    logic                 o_error;

    // slave: the arbiter's view; master: the surrounding pipeline and bus slave
    modport slave (
        input  i_fetch_request, i_fetch_address,
        input  i_mem_request, i_mem_rw, i_mem_address, i_mem_wdata,
        input  i_bus_ready, i_bus_rdata,
        output o_fetch_ready, o_fetch_rdata, o_mem_ready, o_mem_rdata,
        output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
        output o_error
    );

    modport master (
        output i_fetch_request, i_fetch_address,
        output i_mem_request, i_mem_rw, i_mem_address, i_mem_wdata,
        output i_bus_ready, i_bus_rdata,
        input  o_fetch_ready, o_fetch_rdata, o_mem_ready, o_mem_rdata,
        input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
        input  o_error
    );

endinterface

// File: rtl/cpu_bus_watchdog.sv
// rtl/cpu_bus_watchdog.sv - counts busy bus cycles and flags when TIMEOUT is reached
module cpu_bus_watchdog
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = counter_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count is 0 in the first busy cycle, so expiry lands after TIMEOUT full cycles.
    assign expired = (TIMEOUT != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - two-master (fetch / memory stage) CPU bus arbiter with starvation guard and watchdog
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    cpu_bus_arbiter_if.slave   bus
);

    localparam int                  STARVE_W   = counter_width(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    bus_state_e           state_q, state_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 rw_q, rw_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;

    grant_owner_e owner;
    logic         active;
    logic         expired;
    logic         abort;
    logic         fetch_ready;
    logic         mem_ready;

    assign owner  = state_owner(state_q);
    assign active = (owner != OWNER_NONE);
    // A ready arriving on the expiry cycle still completes the transfer.
    assign abort  = expired && !bus.i_bus_ready;

    cpu_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .clear     (!active),
        .enable    (active),
        .expired   (expired)
    );

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.i_mem_request &&
                    !((starve_q == STARVE_MAX) && bus.i_fetch_request)) begin
                    state_d = MEM;
                    rw_d    = bus.i_mem_rw;
                    addr_d  = bus.i_mem_address;
                    wdata_d = bus.i_mem_wdata;
                    if (bus.i_fetch_request) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                end else if (bus.i_fetch_request) begin
                    state_d  = FETCH;
                    rw_d     = 1'b0;
                    addr_d   = bus.i_fetch_address;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            FETCH, MEM: begin
                if (bus.i_bus_ready || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // A master that dropped its request mid-transfer gets neither ready nor data.
    assign fetch_ready = (owner == OWNER_PORT0) && bus.i_bus_ready && bus.i_fetch_request;
    assign mem_ready   = (owner == OWNER_PORT1) && bus.i_bus_ready && bus.i_mem_request;

    assign bus.o_fetch_ready = fetch_ready;
    assign bus.o_fetch_rdata = fetch_ready ? bus.i_bus_rdata : '0;
    assign bus.o_mem_ready   = mem_ready;
    assign bus.o_mem_rdata   = mem_ready ? bus.i_bus_rdata : '0;

    assign bus.o_bus_request = active && !abort;
    assign bus.o_bus_rw      = rw_q;
    assign bus.o_bus_address = addr_q;
    assign bus.o_bus_wdata   = wdata_q;
    assign bus.o_error       = abort;

endmodule
